// File: rtl/class_argmax_sequencer_if.sv
// class_argmax_sequencer_if: pipeline control and prediction signals of the argmax sequencer
interface class_argmax_sequencer_if #(parameter int INT_SIZE = 32, parameter int CLASS_W = 4);
  logic start, pipe_done, pipe_rst, busy, pred_valid;
  logic signed [INT_SIZE-1:0] class_sum_th, pred_sum;
  logic [CLASS_W-1:0] class_sel, pred_class;
  modport master(output start, pipe_done, class_sum_th, input pipe_rst, class_sel, busy, pred_valid, pred_class, pred_sum);
  modport slave(input start, pipe_done, class_sum_th, output pipe_rst, class_sel, busy, pred_valid, pred_class, pred_sum);
endinterface

// File: rtl/class_argmax_sequencer.sv
// class_argmax_sequencer: runs the inference pipeline once per class and reports the signed argmax
module class_argmax_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int INT_SIZE = 32,
  parameter int CLASS_W = 4,
  parameter int RST_CYCLES = 2
) (
  input logic clk,
  input logic rst_flag,
  class_argmax_sequencer_if.slave io
);
  localparam int CNT_W = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, FINISH} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CLASS_W-1:0] sel_q, sel_d, best_idx_q, best_idx_d, pred_class_q, pred_class_d;
  logic signed [INT_SIZE-1:0] best_sum_q, best_sum_d, pred_sum_q, pred_sum_d;
  logic done_q, pipe_rst_q, pipe_rst_d, busy_q, busy_d, pred_valid_q, pred_valid_d;
  logic acc, upd, last;
  always_comb begin
    acc = state_q == RUN && io.pipe_done && !done_q;
    upd = acc && (sel_q == '0 || io.class_sum_th > best_sum_q);
    last = sel_q == CLASS_W'(NUM_CLASSES - 1);
    best_sum_d = upd ? io.class_sum_th : best_sum_q;
    best_idx_d = upd ? sel_q : best_idx_q;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    pred_class_d = pred_class_q;
    pred_sum_d = pred_sum_q;
    if (state_q == IDLE && io.start) begin
      state_d = LAUNCH;
      sel_d = '0;
      cnt_d = '0;
    end
    if (state_q == LAUNCH && cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = RUN;
    // the winner including this cycle's capture is published as FINISH is entered
    if (acc && last) begin
      state_d = FINISH;
      pred_class_d = best_idx_d;
      pred_sum_d = best_sum_d;
    end
    if (acc && !last) begin
      state_d = LAUNCH;
      sel_d = sel_q + 1'b1;
      cnt_d = '0;
    end
    if (state_q == FINISH) state_d = IDLE;
    pipe_rst_d = state_d != RUN;
    busy_d = state_d != IDLE;
    pred_valid_d = state_d == FINISH;
  end
  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sel_q <= '0;
      best_idx_q <= '0;
      best_sum_q <= '0;
      pred_class_q <= '0;
      pred_sum_q <= '0;
      done_q <= 1'b0;
      pipe_rst_q <= 1'b1;
      busy_q <= 1'b0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      best_idx_q <= best_idx_d;
      best_sum_q <= best_sum_d;
      pred_class_q <= pred_class_d;
      pred_sum_q <= pred_sum_d;
      done_q <= io.pipe_done;
      pipe_rst_q <= pipe_rst_d;
      busy_q <= busy_d;
      pred_valid_q <= pred_valid_d;
    end
  end
  assign io.pipe_rst = pipe_rst_q;
  assign io.class_sel = sel_q;
  assign io.busy = busy_q;
  assign io.pred_valid = pred_valid_q;
  assign io.pred_class = pred_class_q;
  assign io.pred_sum = pred_sum_q;
endmodule

// File: tb/tb_class_argmax_sequencer.sv
// tb_class_argmax_sequencer: directed runs with a prediction scoreboard and protocol monitors
module tb_class_argmax_sequencer;
  localparam int NC = 4, RC = 2, IS = 32, CW = 4;
  typedef struct {logic [CW-1:0] cls; int sum;} pred_t;
  logic clk = 1'b0, rst_flag = 1'b0;
  pred_t exp_q[$];
  int n_chk = 0, n_fail = 0, rcnt = 0;
  bit busy_chk = 1'b0;
  class_argmax_sequencer_if #(.INT_SIZE(IS), .CLASS_W(CW)) io();
  class_argmax_sequencer #(.NUM_CLASSES(NC), .INT_SIZE(IS), .CLASS_W(CW), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_flag(rst_flag), .io(io));
  always #5 clk = ~clk;
  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    pred_t e;
    if (busy_chk) check("busy_fall", longint'(io.busy), 0);
    busy_chk = 1'b0;
    if (io.pred_valid) begin
      busy_chk = 1'b1;
      if (exp_q.size() == 0) check("unexpected_pred_valid", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("pred_class", longint'(io.pred_class), longint'(e.cls));
        check("pred_sum", longint'($signed(io.pred_sum)), longint'(e.sum));
      end
    end
    if (!io.busy) rcnt = 0;
    else if (io.pipe_rst) rcnt++;
    else if (rcnt != 0) begin
      check("pipe_rst_len", rcnt, RC);
      rcnt = 0;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    io.start = 1'b1;
    tick();
    io.start = 1'b0;
  endtask
  task automatic wait_run(int sel);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!io.pipe_rst) break;
    end
    check("run_entered", longint'(io.pipe_rst), 0);
    check("class_sel", longint'(io.class_sel), sel);
    tick();
  endtask
  task automatic run_class(int sum, int sel, bit poke_start);
    wait_run(sel);
    repeat (9) tick();
    io.class_sum_th = sum;
    io.pipe_done = 1'b1;
    tick();
    io.pipe_done = 1'b0;
    io.start = poke_start;
    tick();
    io.start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !io.busy) break;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_busy", longint'(io.busy), 0);
    tick();
  endtask
  task automatic infer(int s0, int s1, int s2, int s3, int cls, int sum);
    exp_q.push_back('{cls: CW'(cls), sum: sum});
    tick();
    do_start();
    run_class(s0, 0, 0);
    run_class(s1, 1, 0);
    run_class(s2, 2, 0);
    run_class(s3, 3, 0);
    wait_idle();
  endtask
  task automatic check_reset_outputs();
    check("rst_pipe_rst", longint'(io.pipe_rst), 1);
    check("rst_busy", longint'(io.busy), 0);
    check("rst_pred_valid", longint'(io.pred_valid), 0);
    check("rst_pred_class", longint'(io.pred_class), 0);
    check("rst_pred_sum", longint'($signed(io.pred_sum)), 0);
    check("rst_class_sel", longint'(io.class_sel), 0);
  endtask
  initial begin
    io.start = 1'b0;
    io.pipe_done = 1'b0;
    io.class_sum_th = '0;
    #12;
    check_reset_outputs();
    rst_flag = 1'b1;
    infer(5, -3, 12, 7, 2, 12);
    infer(9, 9, -1, 9, 0, 9);
    infer(-10, -2, -30, -2, 1, -2);
    // stale done held high from before the start must not be captured
    exp_q.push_back('{cls: CW'(2), sum: 6});
    io.pipe_done = 1'b1;
    io.class_sum_th = 99;
    tick();
    do_start();
    wait_run(0);
    repeat (3) tick();
    check("stale_sel", longint'(io.class_sel), 0);
    check("stale_still_run", longint'(io.pipe_rst), 0);
    do_start();
    check("start_in_run_sel", longint'(io.class_sel), 0);
    io.pipe_done = 1'b0;
    tick();
    io.class_sum_th = 4;
    io.pipe_done = 1'b1;
    tick();
    io.pipe_done = 1'b0;
    tick();
    run_class(1, 1, 0);
    run_class(6, 2, 0);
    run_class(2, 3, 1);
    wait_idle();
    repeat (20) tick();
    check("start_in_finish_ignored", longint'(io.busy), 0);
    // abort during class 2 of an inference, then rerun cleanly
    do_start();
    run_class(50, 0, 0);
    run_class(60, 1, 0);
    wait_run(2);
    #2;
    rst_flag = 1'b0;
    #1;
    check_reset_outputs();
    #4;
    rst_flag = 1'b1;
    repeat (15) tick();
    check("abort_no_pred", exp_q.size(), 0);
    infer(1, 8, 3, 2, 1, 8);
    repeat (5) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/class_argmax_sequencer.md
Name: class_argmax_sequencer

Overview:
- Downstream of the TM inference pipeline, which produces one thresholded class sum per run.
- Runs the pipeline once per class: holds it in reset, selects the class's TA bank via class_sel, waits for done, captures class_sum_th.
- Keeps a running signed maximum over all classes and emits the predicted class with a one-cycle valid pulse.

Parameters:
NUM_CLASSES, 10, number of classes evaluated per inference (>=1)
INT_SIZE, 32, width of class_sum_th and pred_sum
CLASS_W, 4, width of class index; must satisfy 2**CLASS_W >= NUM_CLASSES
RST_CYCLES, 2, cycles pipe_rst is held high before each class run (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_flag  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse; begins an inference; ignored while busy=1
pipe_done  input  1  done from the pipeline (level)
class_sum_th  input  INT_SIZE  signed thresholded class sum from the pipeline
pipe_rst  output  1  active-high reset to the pipeline
class_sel  output  CLASS_W  index of the class currently being run (TA bank select)
busy  output  1  high in every state except IDLE
pred_valid  output  1  one-cycle pulse when the prediction is ready
pred_class  output  CLASS_W  argmax class index
pred_sum  output  INT_SIZE  signed sum of the winning class

Behaviour:
- Reset (rst_flag=0, async) takes effect immediately, including mid-run:
  - state=IDLE; pipe_rst=1; class_sel=0; busy=0; pred_valid=0; pred_class=0; pred_sum=0.
  - Internal best_sum, best_idx, rst counter and done_d are cleared.
  - No pred_valid pulse is produced for the aborted inference.
- States: IDLE, LAUNCH, RUN, FINISH.
- IDLE:
  - pipe_rst=1, busy=0.
  - start=1 -> LAUNCH; class_sel<=0; rst counter<=0.
- LAUNCH:
  - pipe_rst=1, busy=1.
  - Counter increments each cycle; after exactly RST_CYCLES cycles in LAUNCH -> RUN.
- RUN:
  - pipe_rst=0, busy=1.
  - done_d samples pipe_done every cycle, in all states.
  - Accept event = pipe_done=1 AND done_d=0 (rising edge only). A done already high on entry to RUN is stale and ignored until it falls and rises again.
- On an accept event (same clock edge):
  - If class_sel==0 or class_sum_th > best_sum (signed, full INT_SIZE compare): best_sum<=class_sum_th; best_idx<=class_sel.
  - Ties keep the earlier (lowest) index.
  - If class_sel==NUM_CLASSES-1 -> FINISH; else class_sel<=class_sel+1 and -> LAUNCH, with the counter cleared.
- FINISH (one cycle):
  - pred_valid=1; pred_class<=best_idx and pred_sum<=best_sum (registered, visible while pred_valid=1); pipe_rst=1; busy=1; -> IDLE.
  - pred_class and pred_sum hold their values until the next FINISH or reset.
- start is ignored while busy=1, including in the FINISH cycle. A start pulse is accepted only in IDLE.
- Timing from a start pulse accepted on edge k:
  - pipe_rst stays high through edge k+RST_CYCLES; RUN begins after that edge.
  - After the final accept event, pred_valid asserts in the next cycle.
- NUM_CLASSES=1: a single class run, then FINISH with pred_class=0.
- class_sel never exceeds NUM_CLASSES-1 and does not wrap within an inference.
- No arithmetic overflow is possible: compare only, no accumulation.

Test Plan:
1. Reset: assert rst_flag=0 asynchronously mid-cycle -> outputs change immediately to pipe_rst=1, busy=0, pred_valid=0, pred_class=0, pred_sum=0, class_sel=0.
2. NUM_CLASSES=4, RST_CYCLES=2; sums {5,-3,12,7}, done rising 10 cycles after each pipe_rst release.
   - pipe_rst high exactly 2 cycles before each run.
   - class_sel steps 0..3.
   - Single pred_valid pulse with pred_class=2, pred_sum=12; busy falls the cycle after.
3. Ties and negatives: sums {9,9,-1,9} -> pred_class=0, pred_sum=9. Sums {-10,-2,-30,-2} -> pred_class=1, pred_sum=-2 (signed compare, no unsigned wrap).
4. Stale done:
   - Hold pipe_done=1 across LAUNCH into RUN -> no capture, class_sel unchanged.
   - Drop pipe_done for 1 cycle, then raise with sum 4 -> captured exactly once, class_sel advances.
   - start pulsed during RUN and during FINISH -> ignored; only one pred_valid pulse.
5. Mid-operation reset: rst_flag=0 while RUN at class_sel=2 -> immediate IDLE, pipe_rst=1, no pred_valid. New start -> class_sel=0, and the prediction uses only the new sums {1,8,3,2} -> pred_class=1.
